// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_pkg
// Brief    : Opcodes, instruction field layout and FSM encoding for the
//            instruction fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package instr_fetch_unit_pkg;

    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] OP_NOP  = 5'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 5'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd2;
    localparam logic [OP_W-1:0] OP_AND  = 5'd3;
    localparam logic [OP_W-1:0] OP_OR   = 5'd4;
    localparam logic [OP_W-1:0] OP_HALT = 5'd31;

    // Fixed field layout; bits [1:0] are reserved.
    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 11;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RS1_LSB = 5;
    localparam int unsigned RS2_LSB = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

endpackage : instr_fetch_unit_pkg
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Sequential fetch stage: owns the PC, fetches over req/ack, holds
//            the instruction register and issues decoded fields valid/stall.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int PC_W       = 8,
    parameter int INSTR_W    = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    output logic [PC_W-1:0]       out_imem_addr,
    output logic                  out_imem_req,
    input  logic                  in_imem_ack,
    input  logic [INSTR_W-1:0]    in_imem_data,
    output logic [OP_W-1:0]       out_op_code,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [REG_ADDR_W-1:0] out_rs1,
    output logic [REG_ADDR_W-1:0] out_rs2,
    output logic                  out_instr_valid,
    input  logic                  in_stall,
    output logic [PC_W-1:0]       out_pc,
    output logic                  out_halted
);

    fetch_state_t         r_state;
    fetch_state_t         w_state_next;
    logic                 w_ack_take;
    logic                 w_valid;
    logic [PC_W-1:0]      r_pc;
    logic [PC_W-1:0]      r_ir_pc;
    logic [INSTR_W-1:0]   r_ir;
    // Reserved instruction bits are intentionally left undecoded.
    logic [INSTR_W-1:0]   w_unused_ir;

    assign w_unused_ir = r_ir;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_ir_pc <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_ack_take) begin
                r_ir    <= in_imem_data;
                r_ir_pc <= r_pc;
                r_pc    <= r_pc + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ack_take   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (in_imem_ack) begin
                    w_ack_take   = 1'b1;
                    w_state_next = (in_imem_data[OP_MSB:OP_LSB] == OP_HALT) ? ST_HALTED : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!in_stall) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded purely from registered state.
    always_comb begin
        w_valid         = (r_state == ST_ISSUE);
        out_instr_valid = w_valid;
        out_imem_req    = (r_state == ST_FETCH);
        out_imem_addr   = r_pc;
        out_halted      = (r_state == ST_HALTED);
        out_pc          = r_ir_pc;
        out_op_code     = w_valid ? r_ir[OP_MSB:OP_LSB] : OP_NOP;
        out_rd          = r_ir[RD_LSB  +: REG_ADDR_W];
        out_rs1         = r_ir[RS1_LSB +: REG_ADDR_W];
        out_rs2         = r_ir[RS2_LSB +: REG_ADDR_W];
    end

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Self-checking bench for instr_fetch_unit with a memory responder
//            and an issue scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam int PC_W = 8;
    localparam int INSTR_W = 16;
    localparam int RW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [PC_W-1:0] imem_addr;
    logic            imem_req;
    logic            imem_ack = 1'b0;
    logic [15:0]     imem_data = 16'h0;
    logic [4:0]      op_code;
    logic [RW-1:0]   rd, rs1, rs2;
    logic            instr_valid;
    logic            stall = 1'b0;
    logic [PC_W-1:0] pc;
    logic            halted;

    instr_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .REG_ADDR_W(RW)) dut (
        .in_clk          (clk),
        .in_rst          (rst),
        .out_imem_addr   (imem_addr),
        .out_imem_req    (imem_req),
        .in_imem_ack     (imem_ack),
        .in_imem_data    (imem_data),
        .out_op_code     (op_code),
        .out_rd          (rd),
        .out_rs1         (rs1),
        .out_rs2         (rs2),
        .out_instr_valid (instr_valid),
        .in_stall        (stall),
        .out_pc          (pc),
        .out_halted      (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        logic [4:0]  op;
        logic [2:0]  rd, rs1, rs2;
    } vec_t;

    typedef struct {
        logic [4:0] op;
        logic [2:0] rd, rs1, rs2;
        logic [7:0] pc;
    } exp_t;

    vec_t        vecs [7];
    logic [15:0] mem [256];
    exp_t        exp_tab [256];
    bit          halt_at [256];
    int          wait_cfg [256];
    int          stall_cfg [256];
    exp_t        sb [$];
    int          wait_cnt, stall_left, cyc, errors, checks, n;
    bit          noise;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s (cycle %0d): actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // One cycle: sample at negedge, check issue, then drive memory and stall.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (instr_valid) begin
            if (stall_left > 0) begin
                stall = 1'b1;
                stall_left--;
            end else begin
                stall = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_valid (cycle %0d): actual pc=%0d required=no issue", cyc, pc);
                end else begin
                    e = sb.pop_front();
                    chk("sb_fields", {op_code, rd, rs1, rs2, pc}, {e.op, e.rd, e.rs1, e.rs2, e.pc});
                end
            end
        end else begin
            chk("op_zero_when_invalid", op_code, 0);
            stall = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (imem_req) begin
            if (wait_cnt < wait_cfg[imem_addr]) begin
                wait_cnt++;
                imem_ack  = 1'b0;
                imem_data = 16'($urandom);
            end else begin
                imem_ack   = 1'b1;
                imem_data  = mem[imem_addr];
                wait_cnt   = 0;
                stall_left = stall_cfg[imem_addr];
                if (!halt_at[imem_addr]) sb.push_back(exp_tab[imem_addr]);
            end
        end else begin
            imem_ack  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_data = 16'($urandom);
        end
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("reset_outputs_zero",
            {imem_req, imem_addr, instr_valid, op_code, halted, pc, rd, rs1, rs2}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        sb.delete();
        wait_cnt   = 0;
        stall_left = 0;
        imem_ack   = 1'b0;
        stall      = 1'b0;
        rst        = 1'b0;
        cyc        = 1;
    endtask

    task automatic load_table();
        for (int a = 0; a < 256; a++) begin
            mem[a]       = 16'h0000;
            exp_tab[a]   = '{5'd0, 3'd0, 3'd0, 3'd0, 8'(a)};
            halt_at[a]   = 1'b0;
            wait_cfg[a]  = 0;
            stall_cfg[a] = 0;
        end
        for (int i = 0; i < 7; i++) begin
            mem[i]     = vecs[i].word;
            exp_tab[i] = '{vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, 8'(i)};
        end
        mem[7]     = 16'hF800;
        halt_at[7] = 1'b1;
    endtask

    task automatic run_to_halt(input string name);
        n = 0;
        while (!halted && n < 100) begin
            tick();
            n++;
        end
        chk(name, halted, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] a8;
        errors = 0;
        checks = 0;
        cyc    = 0;
        noise  = 1'b0;
        vecs[0] = '{16'h0900, 5'd1,  3'd1, 3'd0, 3'd0};
        vecs[1] = '{16'h1124, 5'd2,  3'd1, 3'd1, 3'd1};
        vecs[2] = '{16'h1800, 5'd3,  3'd0, 3'd0, 3'd0};
        vecs[3] = '{16'h2345, 5'd4,  3'd3, 3'd2, 3'd1};
        vecs[4] = '{16'h07FF, 5'd0,  3'd7, 3'd7, 3'd7};
        vecs[5] = '{16'h5ABC, 5'd11, 3'd2, 3'd5, 3'd7};
        vecs[6] = '{16'hF7E0, 5'd30, 3'd7, 3'd7, 3'd0};

        // Zero-wait stream: valid on odd cycles 3..15, then halt at address 7.
        load_table();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("t1_valid_timing", instr_valid, 64'((cyc % 2 == 1) && (cyc <= 15)));
            if (cyc % 2 == 0) chk("t1_req_addr", {imem_req, imem_addr}, {1'b1, 8'((cyc - 2) / 2)});
        end
        noise = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("t1_halted_frozen", {halted, imem_req, instr_valid}, {1'b1, 1'b0, 1'b0});
        end
        chk("t1_sb_drained", sb.size(), 0);

        // Three memory wait cycles at address 0; reset also leaves halt.
        load_table();
        wait_cfg[0] = 3;
        noise = 1'b0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t2_wait_hold", {imem_req, imem_addr, instr_valid, rd}, {1'b1, 8'd0, 1'b0, 3'd0});
        end
        tick();
        chk("t2_first_issue", {instr_valid, pc, rd}, {1'b1, 8'd0, 3'd1});
        noise = 1'b1;
        run_to_halt("t2_reach_halt");

        // Five stall cycles while 0x2345 is issued.
        load_table();
        stall_cfg[3] = 5;
        do_reset();
        n = 0;
        do begin
            tick();
            n++;
        end while (!(instr_valid && pc == 8'd3) && n < 50);
        chk("t3_found", {instr_valid, pc}, {1'b1, 8'd3});
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_stall_hold", {instr_valid, imem_req, op_code, rd, rs1, rs2, pc},
                {1'b1, 1'b0, 5'd4, 3'd3, 3'd2, 3'd1, 8'd3});
        end
        tick();
        chk("t3_last_valid", instr_valid, 1);
        tick();
        chk("t3_next_fetch", {imem_req, imem_addr}, {1'b1, 8'd4});
        run_to_halt("t3_reach_halt");

        // PC wraps from 255 to 0.
        load_table();
        for (int a = 0; a < 256; a++) begin
            a8 = 8'(a);
            mem[a]     = {5'd1, a8, 3'b000};
            exp_tab[a] = '{5'd1, a8[7:5], a8[4:2], {a8[1:0], 1'b0}, a8};
        end
        mem[7]     = {5'd1, 8'd7, 3'b000};
        halt_at[7] = 1'b0;
        do_reset();
        n = 0;
        do begin
            tick();
            n++;
        end while (!(instr_valid && pc == 8'd255) && n < 700);
        chk("t4_pc_255", {instr_valid, pc}, {1'b1, 8'd255});
        n = 0;
        do begin
            tick();
            n++;
        end while (!imem_req && n < 10);
        chk("t4_wrap_addr", {imem_req, imem_addr}, {1'b1, 8'd0});
        n = 0;
        do begin
            tick();
            n++;
        end while (!instr_valid && n < 10);
        chk("t4_wrap_issue", {instr_valid, pc}, {1'b1, 8'd0});

        // Reset in the cycle the ack arrives, then again mid-issue.
        load_table();
        noise = 1'b0;
        do_reset();
        tick();
        chk("t5_ack_cycle", {imem_req, imem_ack}, {1'b1, 1'b1});
        do_reset();
        tick();
        chk("t5_restart", {imem_req, imem_addr, instr_valid}, {1'b1, 8'd0, 1'b0});
        tick();
        chk("t5_first_issue", {instr_valid, pc, op_code}, {1'b1, 8'd0, 5'd1});
        do_reset();
        tick();
        chk("t5_restart_issue", {imem_req, imem_addr, instr_valid}, {1'b1, 8'd0, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_instr_fetch_unit
`default_nettype wire
